// File: rtl/fifo_reg_to_uart_pkg.sv
// Shared widths and state encodings for the UART transmit-side word-to-byte sequencer.
// The width constants match the receive-side byte-to-word register bank.
package fifo_reg_to_uart_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 8;
  localparam int WORD_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_reg_to_uart_piso.sv
// Parallel-in serial-out register: loads a whole word and shifts it out one byte
// at a time, least-significant byte first.
module piso_shift_reg
  import fifo_reg_to_uart_pkg::*;
#(
  parameter int WORD_W_P = WORD_W,
  parameter int BYTE_W_P = BYTE_W
) (
  input  logic                clk,
  input  logic                sys_rst_l,
  input  logic                load,
  input  logic                shift,
  input  logic [WORD_W_P-1:0] D_in,
  output logic [BYTE_W_P-1:0] D_out
);

  logic [WORD_W_P-1:0] r_shift;

  // Zeros fill from the top, so the register reads empty once all bytes have left.
  always_ff @(posedge clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_shift <= '0;
    end else if (load) begin
      r_shift <= D_in;
    end else if (shift) begin
      r_shift <= {BYTE_W_P'(0), r_shift[WORD_W_P-1:BYTE_W_P]};
    end
  end

  assign D_out = r_shift[BYTE_W_P-1:0];

endmodule

// File: rtl/fifo_reg_to_uart.sv
// Transmit sequencer: captures one word on load and pushes its bytes, LSB first,
// into the UART TX FIFO while honouring the FIFO full flag.
module fifo_reg_to_uart
  import fifo_reg_to_uart_pkg::*;
#(
  parameter int pos_array = WORD_BYTES,
  parameter int byte_out  = BYTE_W,
  parameter int data_fifo = WORD_W
) (
  input  logic                 clk,
  input  logic                 sys_rst_l,
  input  logic                 load,
  input  logic [data_fifo-1:0] Din,
  input  logic                 tx_full,
  output logic                 wr_en,
  output logic [byte_out-1:0]  Dout,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(pos_array);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(pos_array - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  assign w_accept = (r_state == ST_IDLE) && load;
  // tx_full comes straight from a registered FIFO flag, so this path is loop-free.
  assign wr_en    = (r_state == ST_SEND) && !tx_full;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);

  piso_shift_reg #(
    .WORD_W_P (data_fifo),
    .BYTE_W_P (byte_out)
  ) u_piso (
    .clk       (clk),
    .sys_rst_l (sys_rst_l),
    .load      (w_accept),
    .shift     (wr_en),
    .D_in      (Din),
    .D_out     (Dout)
  );

  always_ff @(posedge clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (load) w_nextState = ST_SEND;
      ST_SEND: if (wr_en && (r_cnt == LAST_CNT)) w_nextState = ST_DONE;
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Byte index within the word; it only advances on an actual push.
  always_ff @(posedge clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (wr_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_reg_to_uart.sv
// Self-checking bench for fifo_reg_to_uart: directed scenarios plus random traffic,
// all compared against a byte-queue reference model.
module tb_fifo_reg_to_uart;

  logic        clk;
  logic        sysRstL;
  logic        load;
  logic [63:0] din;
  logic        txFull;
  logic        wrEn;
  logic [7:0]  dout;
  logic        busy;
  logic        done;

  int compareCount;
  int mismatchCount;

  // Reference model: bytes still owed to the FIFO, plus a pending completion pulse.
  logic [7:0] modelQ[$];
  bit         modelDone;

  int cycle;
  int loadCycle;
  int doneCycle;
  int pushCount;

  fifo_reg_to_uart dut (
    .clk       (clk),
    .sys_rst_l (sysRstL),
    .load      (load),
    .Din       (din),
    .tx_full   (txFull),
    .wr_en     (wrEn),
    .Dout      (dout),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Drives one clock cycle of inputs, checks outputs mid-cycle, then advances the model.
  task automatic applyStimulus(input logic ld, input logic [63:0] d, input logic full);
    logic expBusy;
    logic expWr;
    @(negedge clk);
    load   = ld;
    din    = d;
    txFull = full;
    #1;
    expBusy = (modelQ.size() != 0) || modelDone;
    expWr   = (modelQ.size() != 0) && !full;
    checkOutput("busy", 64'(busy), 64'(expBusy));
    checkOutput("wr_en", 64'(wrEn), 64'(expWr));
    checkOutput("done", 64'(done), 64'(modelDone));
    if (expWr) checkOutput("Dout", 64'(dout), 64'(modelQ[0]));
    if (wrEn) pushCount++;
    if (done) doneCycle = cycle;
    @(posedge clk);
    if (modelDone) modelDone = 1'b0;
    if (expWr) begin
      void'(modelQ.pop_front());
      if (modelQ.size() == 0) modelDone = 1'b1;
    end
    if (!expBusy && ld) begin
      for (int k = 0; k < 8; k++) modelQ.push_back(d[8*k +: 8]);
      loadCycle = cycle;
    end
    cycle++;
  endtask

  task automatic doReset();
    @(negedge clk);
    sysRstL = 1'b0;
    load    = 1'b0;
    txFull  = 1'b0;
    #1;
    checkOutput("rst_wr_en", 64'(wrEn), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_Dout", 64'(dout), 64'(8'h00));
    modelQ.delete();
    modelDone = 1'b0;
    @(negedge clk);
    sysRstL = 1'b1;
  endtask

  localparam logic [63:0] WORD_A = 64'h8877665544332211;

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    cycle     = 0;
    loadCycle = 0;
    doneCycle = -1;
    pushCount = 0;
    modelDone = 1'b0;
    sysRstL   = 1'b0;
    load      = 1'b0;
    din       = '0;
    txFull    = 1'b0;
    doReset();

    $display("[TB] basic word, no back-pressure");
    pushCount = 0;
    for (int i = 0; i < 12; i++) applyStimulus(i == 0, WORD_A, 1'b0);
    checkOutput("basic_pushes", 64'(pushCount), 64'(8));
    checkOutput("basic_doneLat", 64'(doneCycle - loadCycle), 64'(9));

    $display("[TB] tx_full high for three cycles mid-word");
    pushCount = 0;
    for (int i = 0; i < 15; i++) applyStimulus(i == 0, WORD_A, (i >= 3) && (i <= 5));
    checkOutput("stall_pushes", 64'(pushCount), 64'(8));
    checkOutput("stall_doneLat", 64'(doneCycle - loadCycle), 64'(12));

    $display("[TB] load during SEND dropped, load after done accepted");
    pushCount = 0;
    for (int i = 0; i < 22; i++) begin
      if (i == 3) applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      else if (i == 10) applyStimulus(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
      else applyStimulus(i == 0, WORD_A, 1'b0);
    end
    checkOutput("reload_pushes", 64'(pushCount), 64'(16));
    checkOutput("reload_doneLat", 64'(doneCycle - loadCycle), 64'(9));

    $display("[TB] reset after the fourth byte");
    pushCount = 0;
    for (int i = 0; i < 5; i++) applyStimulus(i == 0, WORD_A, 1'b0);
    checkOutput("abort_pushesBefore", 64'(pushCount), 64'(4));
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, WORD_A, 1'b0);
    checkOutput("abort_pushesAfter", 64'(pushCount), 64'(4));

    $display("[TB] tx_full high at load and for ten cycles");
    pushCount = 0;
    for (int i = 0; i < 22; i++) applyStimulus(i == 0, WORD_A, i <= 10);
    checkOutput("full_pushes", 64'(pushCount), 64'(8));
    checkOutput("full_doneLat", 64'(doneCycle - loadCycle), 64'(19));

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      applyStimulus($urandom_range(0, 4) == 0, {$urandom, $urandom}, $urandom_range(0, 9) < 3);
    end
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("final_idle", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/fifo_reg_to_uart.md
# fifo_reg_to_uart

Parallel-to-serial byte sequencer for the transmit path: captures one 64-bit result word and pushes it as 8 bytes, least-significant byte first, into the UART transmit FIFO. It honours the FIFO's full flag and signals completion. It is the mirror of the receive-side byte-to-word register bank: byte k of the word occupies bits [8k+7:8k] on both sides.

## Interface

Parameters:
- `pos_array`, 8, number of bytes per word.
- `byte_out`, 8, byte width.
- `data_fifo`, 64, word width; must equal `pos_array*byte_out`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `sys_rst_l`  in  1  reset, asynchronous assert, active-low.
- `load`  in  1  single-cycle request to send `Din`.
- `Din`  in  `data_fifo`  word to transmit; sampled only when `load` is accepted.
- `tx_full`  in  1  UART TX FIFO full; no push is permitted while high.
- `wr_en`  out  1  push strobe to the TX FIFO.
- `Dout`  out  `byte_out`  byte presented with `wr_en`.
- `busy`  out  1  high while a word is in flight; `load` is ignored while high.
- `done`  out  1  one-cycle pulse after the last byte is pushed.

## Operation

- State machine with three states: IDLE, SEND, DONE.
- IDLE:
  - `load`=1: capture `Din` into the shift register, clear the byte counter, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - `wr_en` = !`tx_full` (combinational); `Dout` = shift register [7:0].
  - On each cycle with `wr_en`=1: shift right by `byte_out`, increment the counter.
  - When the counter reaches `pos_array`-1 and a push occurs, go to DONE.
  - While `tx_full`=1: hold the shift register and counter; `wr_en`=0; `Dout` stays stable.
- DONE: assert `done` for exactly one cycle, then go to IDLE.
- `busy` = (state != IDLE).
- A `load` in SEND or DONE is dropped, with no queuing. A `load` in the same cycle as the DONE→IDLE transition is also dropped; the earliest accepted `load` is the cycle after `done`.
- Counter is 3 bits (clog2 of `pos_array`); terminal count is `pos_array`-1. No wrap-around occurs inside a word.
- `Dout` is the raw shift-register LSB byte in every state. It is only meaningful when `wr_en`=1; outside SEND it is don't-care.
- Reset values: state IDLE, shift register 0, counter 0. Hence `wr_en`=0, `busy`=0, `done`=0, `Dout`=8'h00.
- Reset mid-word: abort immediately. Remaining bytes are discarded, no `done` is produced, and no further `wr_en` is issued.

## Timing

- `load` sampled at edge N → `busy`=1 and the first `wr_en` possible in cycle N+1.
- Throughput is one byte per cycle with `tx_full`=0: 8 bytes in cycles N+1..N+8, `done` in N+9, IDLE (new `load` accepted) at N+10.
- Each cycle of `tx_full`=1 during SEND adds exactly one cycle of latency.
- `tx_full` rising in the same cycle as a byte suppresses that push; the byte is retried in the next free cycle. No byte is lost or duplicated.
- `wr_en` depends combinationally on `tx_full`. The FIFO full flag must therefore be a registered output, so no combinational loop forms.

## Structure

- Shared package/header holds:
  - width constants `BYTE_W`=8, `WORD_BYTES`=8, `WORD_W`=64, shared with the receive-side register bank;
  - state encodings `ST_IDLE`=2'd0, `ST_SEND`=2'd1, `ST_DONE`=2'd2.
- One sub-module: `piso_shift_reg`, a parallel-in serial-out register with ports load, shift, `D_in[63:0]`, `D_out[7:0]` and async active-low reset. The top level holds the FSM and counter.

## Test plan

- Reset then `load` with `Din`=64'h8877665544332211, `tx_full`=0 → `wr_en` high cycles N+1..N+8 with `Dout` 11,22,...,88 in order; `done` pulse at N+9; `busy` low at N+10.
- Same word, `tx_full` held high cycles N+3..N+5 → bytes 11,22 pushed, then a 3-cycle gap with `Dout`=33 stable, then 33..88; `done` at N+12; exactly 8 pushes in total.
- Second `load` (64'hFFFF...) pulsed during SEND → ignored; only the first word's 8 bytes appear. A `load` the cycle after `done` → accepted.
- `sys_rst_l` asserted after the 4th byte → `wr_en`, `busy`, `done` low immediately; no further pushes after release until a new `load`.
- `tx_full`=1 at the moment of `load` and for 10 cycles → zero pushes while high; on release, 8 consecutive pushes 11..88; `busy` high throughout.
